// File: rtl/bus_arbiter_if.sv
// Bundle of the two core request ports and the shared memory port.
// The arbiter uses the slave view; the core and memory side use the master view.
interface bus_arbiter_if #(
    parameter int XLEN = 64
);
    logic              instr_re;
    logic [3:0]        instr_sel;
    logic [XLEN-1:0]   instr_addr;
    logic              instr_ack;
    logic [31:0]       instr_data;

    logic              data_re;
    logic              data_we;
    logic [XLEN/8-1:0] data_sel;
    logic [XLEN-1:0]   data_addr;
    logic [XLEN-1:0]   data_w;
    logic              data_ack;
    logic [XLEN-1:0]   data_r;

    logic              mem_cyc;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_sel;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  instr_re, instr_sel, instr_addr,
        output instr_ack, instr_data,
        input  data_re, data_we, data_sel, data_addr, data_w,
        output data_ack, data_r,
        output mem_cyc, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output instr_re, instr_sel, instr_addr,
        input  instr_ack, instr_data,
        output data_re, data_we, data_sel, data_addr, data_w,
        input  data_ack, data_r,
        input  mem_cyc, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// XLEN must be 32 or 64; every output comes straight from a register.
package pipeline;
    parameter int XLEN = 64;
endpackage

module bus_arbiter #(
    parameter int XLEN  = pipeline::XLEN,
    parameter int BLANK = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  bus
);
    localparam int SELW = XLEN / 8;
    localparam int CNTW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
    localparam logic [CNTW-1:0] BLANK_LD = CNTW'(BLANK);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t          state;
    logic            last_instr;   // round-robin pointer: 1 when the last grant went to fetch
    logic [CNTW-1:0] instr_blank;
    logic [CNTW-1:0] data_blank;

    logic            instr_pend;
    logic            data_pend;
    logic            pick_instr;
    logic [SELW-1:0] instr_lanes;
    logic [31:0]     fetch_word;

    // NOTE: every signal gets a default at the top so no path through the block infers a latch.
    always_comb begin
        instr_pend  = bus.instr_re && (instr_blank == '0);
        data_pend   = (bus.data_re || bus.data_we) && (data_blank == '0);
        pick_instr  = instr_pend && (!data_pend || !last_instr);
        instr_lanes = SELW'(bus.instr_sel);
        if (XLEN == 64 && bus.instr_addr[2]) instr_lanes = instr_lanes << 4;
        // mem_addr still holds the fetch address while the fetch is outstanding
        fetch_word = bus.mem_rdata[31:0];
        if (XLEN == 64 && bus.mem_addr[2]) fetch_word = bus.mem_rdata[XLEN-1 -: 32];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_instr     <= 1'b0;
            instr_blank    <= '0;
            data_blank     <= '0;
            bus.instr_ack  <= 1'b0;
            bus.instr_data <= '0;
            bus.data_ack   <= 1'b0;
            bus.data_r     <= '0;
            bus.mem_cyc    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_sel    <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.instr_ack <= 1'b0;
            bus.data_ack  <= 1'b0;
            if (instr_blank != '0) instr_blank <= instr_blank - CNTW'(1);
            if (data_blank != '0)  data_blank  <= data_blank - CNTW'(1);

            case (state)
                IDLE: begin
                    // the cycle that carries an ack never starts a new grant
                    if (!bus.instr_ack && !bus.data_ack) begin
                        if (pick_instr) begin
                            state         <= INSTR;
                            last_instr    <= 1'b1;
                            bus.mem_cyc   <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_sel   <= instr_lanes;
                            bus.mem_addr  <= bus.instr_addr;
                            bus.mem_wdata <= '0;
                        end else if (data_pend) begin
                            state         <= DATA;
                            last_instr    <= 1'b0;
                            bus.mem_cyc   <= 1'b1;
                            bus.mem_we    <= bus.data_we;
                            bus.mem_sel   <= bus.data_sel;
                            bus.mem_addr  <= bus.data_addr;
                            bus.mem_wdata <= bus.data_w;
                        end
                    end
                end
                INSTR: begin
                    if (bus.mem_ack) begin
                        state          <= IDLE;
                        bus.mem_cyc    <= 1'b0;
                        bus.instr_ack  <= 1'b1;
                        bus.instr_data <= fetch_word;
                        instr_blank    <= BLANK_LD;
                    end
                end
                DATA: begin
                    if (bus.mem_ack) begin
                        state        <= IDLE;
                        bus.mem_cyc  <= 1'b0;
                        bus.data_ack <= 1'b1;
                        bus.data_r   <= bus.mem_rdata;
                        data_blank   <= BLANK_LD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table of single transactions plus
// hand-written contention, blanking and mid-cycle reset sequences.
module tb_bus_arbiter;
    localparam int XLEN  = 64;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.XLEN(XLEN)) bus ();

    bus_arbiter #(.XLEN(XLEN), .BLANK(BLANK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_instr_data = '0;
    logic [63:0] exp_data_r     = '0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    typedef struct {
        logic        is_instr;
        logic        d_re;
        logic        d_we;
        logic [7:0]  sel;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        logic [7:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[6];

    task automatic idle_inputs();
        bus.instr_re   = 1'b0;
        bus.instr_sel  = '0;
        bus.instr_addr = '0;
        bus.data_re    = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_sel   = '0;
        bus.data_addr  = '0;
        bus.data_w     = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_zero"},
              {bus.mem_cyc, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, '0);
        check({tag, ".core_zero"},
              {bus.instr_ack, bus.data_ack, bus.instr_data, bus.data_r}, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_instr_data = '0;
        exp_data_r     = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] exp_wdata;
        int waited;
        exp_wdata = v.is_instr ? 64'h0 : v.wdata;
        @(negedge clk);
        bus.instr_re   = v.is_instr;
        bus.instr_sel  = v.sel[3:0];
        bus.instr_addr = v.addr;
        bus.data_re    = v.d_re;
        bus.data_we    = v.d_we;
        bus.data_sel   = v.sel;
        bus.data_addr  = v.addr;
        bus.data_w     = v.wdata;
        @(negedge clk);
        waited = 0;
        while (!bus.mem_cyc && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, ".grant_latency"}, waited, 0);
        check({tag, ".mem_port"},
              {bus.mem_cyc, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata},
              {1'b1, v.exp_we, v.exp_sel, v.addr, exp_wdata});
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            check({tag, ".hold"},
                  {bus.instr_ack, bus.data_ack, bus.mem_cyc, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata},
                  {2'b00, 1'b1, v.exp_we, v.exp_sel, v.addr, exp_wdata});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.instr_re = 1'b0;
        bus.data_re  = 1'b0;
        bus.data_we  = 1'b0;
        if (v.is_instr) exp_instr_data = v.exp_instr;
        else            exp_data_r     = v.rdata;
        check({tag, ".ack"}, {bus.instr_ack, bus.data_ack, bus.mem_cyc},
              {v.is_instr, !v.is_instr, 1'b0});
        check({tag, ".rdata"}, {bus.instr_data, bus.data_r}, {exp_instr_data, exp_data_r});
        @(negedge clk);
        check({tag, ".ack_pulse"}, {bus.instr_ack, bus.data_ack}, 2'b00);
        repeat (2) @(negedge clk);
    endtask

    // both ports request continuously; the memory acks every cycle it sees mem_cyc
    task automatic contention();
        byte order[$];
        logic first_seen;
        first_seen = 1'b0;
        @(negedge clk);
        bus.instr_re   = 1'b1;
        bus.instr_sel  = 4'hF;
        bus.instr_addr = 64'h100;
        bus.data_re    = 1'b1;
        bus.data_sel   = 8'hFF;
        bus.data_addr  = 64'h200;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.mem_cyc && !first_seen) begin
                first_seen = 1'b1;
                check("rr.first_grant_instr", bus.mem_addr, 64'h100);
            end
            if (bus.instr_ack || bus.data_ack) begin
                check("rr.no_grant_in_ack_cycle", {bus.mem_cyc, bus.instr_ack & bus.data_ack}, 2'b00);
                order.push_back(bus.instr_ack ? "I" : "D");
            end
            bus.mem_ack = bus.mem_cyc;
        end
        bus.mem_ack = 1'b0;
        idle_inputs();
        check("rr.ack_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr.order%0d", i), order[i], (i % 2 == 0) ? "I" : "D");
    endtask

    task automatic blanking();
        int waited;
        @(negedge clk);
        bus.instr_re   = 1'b1;
        bus.instr_sel  = 4'hF;
        bus.instr_addr = 64'h500;
        bus.mem_rdata  = 64'hFFFF0000_00C0FFEE;
        @(negedge clk);
        waited = 0;
        while (!bus.mem_cyc && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("blank.first_grant", {bus.mem_cyc, waited}, {1'b1, 32'd0});
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        exp_instr_data = 32'h00C0FFEE;
        check("blank.ack", {bus.instr_ack, bus.instr_data}, {1'b1, exp_instr_data});
        @(negedge clk);
        check("blank.hold1", {bus.mem_cyc, bus.instr_ack}, 2'b00);
        @(negedge clk);
        check("blank.hold2", {bus.mem_cyc, bus.instr_ack}, 2'b00);
        bus.instr_re = 1'b0;
        @(negedge clk);
        check("blank.dropped", {bus.mem_cyc, bus.instr_ack}, 2'b00);
        bus.instr_re = 1'b1;
        @(negedge clk);
        check("blank.regrant", {bus.mem_cyc, bus.mem_addr}, {1'b1, 64'h500});
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.instr_re = 1'b0;
        check("blank.second_ack", {bus.instr_ack, bus.mem_cyc}, 2'b10);
        repeat (3) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        bus.data_we   = 1'b1;
        bus.data_sel  = 8'hFF;
        bus.data_addr = 64'h900;
        bus.data_w    = 64'h1;
        @(negedge clk);
        check("mrst.granted", {bus.mem_cyc, bus.mem_we, bus.mem_addr}, {2'b11, 64'h900});
        repeat (4) @(negedge clk);
        check("mrst.wait_no_timeout", {bus.mem_cyc, bus.mem_addr, bus.data_ack}, {1'b1, 64'h900, 1'b0});
        check("mrst.prior_data", {bus.instr_data, bus.data_r}, {exp_instr_data, exp_data_r});
        #2;
        reset_n = 1'b0;
        bus.data_we = 1'b0;
        #1;
        check_all_zero("mrst.async");
        @(negedge clk);
        reset_n = 1'b1;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mrst.stray_ack%0d", c),
                  {bus.instr_ack, bus.data_ack, bus.mem_cyc, bus.data_r}, '0);
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          instr re   we   sel    addr                   wdata                  rdata                  dly exp_sel we  exp_instr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h0F, 64'h1004,             64'h0,                 64'hDEADBEEF_00000013, 0, 8'hF0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h03, 64'h2000,             64'h0,                 64'h11112222_33334444, 1, 8'h03, 1'b0, 32'h33334444};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'hFF, 64'h8000,             64'h1234,              64'hCAFEF00D_12345678, 2, 8'hFF, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h0F, 64'h40,               64'h55,                64'h0,                 5, 8'h0F, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'hF0, 64'h48,               64'hA5A5A5A5_5A5A5A5A, 64'h77,                0, 8'hF0, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h0C, 64'h3FFC,             64'h0,                 64'h89ABCDEF_01234567, 3, 8'hC0, 1'b0, 32'h89ABCDEF};

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        contention();
        pulse_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        blanking();
        mid_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default pipeline::XLEN (64), meaning data/address width; XLEN SHALL be 32 or 64.
REQ-002 The block SHALL have parameter BLANK, default 2, meaning the number of cycles a port's request is ignored after that port is acked.
REQ-003 The block SHALL have the ports listed below (clock, reset, instruction slave, data slave, memory master):
- clk  input  1  sole clock, all state on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- instr_re  input  1  instruction fetch request.
- instr_sel  input  4  instruction byte lanes.
- instr_addr  input  XLEN  fetch byte address.
- instr_ack  output  1  one-cycle fetch completion.
- instr_data  output  32  fetched instruction.
- data_re  input  1  data read request.
- data_we  input  1  data write request.
- data_sel  input  XLEN/8  data byte lanes.
- data_addr  input  XLEN  data byte address.
- data_w  input  XLEN  write data.
- data_ack  output  1  one-cycle data completion.
- data_r  output  XLEN  read data.
- mem_cyc  output  1  memory cycle active.
- mem_we  output  1  memory write.
- mem_sel  output  XLEN/8  memory byte lanes.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_ack  input  1  memory completion, one cycle, may be combinational from mem_cyc.
- mem_rdata  input  XLEN  memory read data, valid with mem_ack.

Function
REQ-004 The block SHALL be an FSM with states IDLE, INSTR, DATA; every output SHALL be driven from a register.
REQ-005 A port is pending when (instr_re) or (data_re|data_we), respectively, and its blanking counter is zero.
REQ-006 In IDLE with one port pending, the FSM SHALL grant that port at the next edge; with both pending, it SHALL grant the port not granted last (round-robin pointer, updated at each grant).
REQ-007 On grant, the block SHALL register mem_cyc=1 and the port's addr/sel/we/wdata, and hold them stable until the cycle in which mem_ack=1.
REQ-008 INSTR grant: mem_we=0, mem_wdata=0, mem_addr=instr_addr; for XLEN=64 mem_sel = instr_sel shifted to bits [7:4] when instr_addr[2]=1, else bits [3:0]; for XLEN=32 mem_sel=instr_sel.
REQ-009 DATA grant: mem_we=data_we (write wins if data_re and data_we both set), mem_sel=data_sel, mem_addr=data_addr, mem_wdata=data_w.
REQ-010 On mem_ack in INSTR or DATA, the next edge SHALL set mem_cyc=0, return to IDLE, pulse the owning port's ack for exactly one cycle, and capture read data: instr_data = mem_rdata[63:32] if the latched instr_addr[2]=1 (XLEN=64) else mem_rdata[31:0]; data_r = mem_rdata (writes capture mem_rdata too, value unspecified to the core).
REQ-011 instr_data and data_r SHALL hold their last captured value until the next completion for that port.
REQ-012 The ack edge SHALL load the acked port's blanking counter with BLANK; it decrements each cycle to zero; a non-acked port's counter is unaffected.
REQ-013 A new grant SHALL NOT occur in the cycle an ack is asserted (IDLE entered that cycle); earliest re-grant is the following edge.
REQ-014 mem_ack while mem_cyc=0 SHALL be ignored.
REQ-015 Minimum latency: request visible cycle 0 -> mem_cyc=1 cycle 1 -> (mem_ack cycle 1) -> port ack cycle 2.
REQ-016 No timeout: a granted cycle SHALL wait indefinitely for mem_ack while holding all memory outputs.

Reset
REQ-017 reset_n=0 SHALL immediately force IDLE, round-robin pointer = instruction-first, blanking counters 0, and all outputs (acks, mem_*, instr_data, data_r) to 0, including mid-transaction; an in-flight memory cycle is abandoned without ack.

Verification
REQ-018 Single fetch: instr_re=1, addr=0x1004, sel=0xF, XLEN=64, mem_ack next cycle with rdata=0xDEADBEEF_00000013 -> mem_sel=0xF0, instr_ack pulse cycle 2, instr_data=0xDEADBEEF.
REQ-019 Contention: instr_re and data_re both held from cycle 0 after reset -> grants INSTR, DATA, INSTR alternating; no port acked twice in a row while the other pends.
REQ-020 Blanking: instr_re held high 2 cycles past instr_ack, BLANK=2 -> no duplicate fetch issued; a genuine re 3 cycles after ack is granted.
REQ-021 Write: data_we=1, data_re=1, sel=0x0F, data_w=0x55, mem_ack delayed 5 cycles -> mem_we=1, outputs stable 5 cycles, one data_ack pulse.
REQ-022 Reset mid-cycle: reset_n low while mem_cyc=1 -> all outputs 0 asynchronously; after release, stray mem_ack produces no ack.
